ahb_im_bridge: RTL and testbench
================================

Name: ahb_im_bridge

Overview:
- AHB-Lite slave front-end sitting directly upstream of the instruction memory; converts bus read transfers into IM enable/address requests and returns IM_out on HRDATA.
- Honours the IM stall handshake: each fetch holds IM_enable and IM_address until IM_stall drops.
- Instruction memory is read-only from the bus; illegal transfers get a two-cycle AHB ERROR response.

Parameters:
- IM_AW, 16, IM word-address width; IM_address = HADDR[IM_AW+1:2].
- DATA_WIDTH, 32, bus and IM data width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  write transfer
- HSIZE  in  3  transfer size
- HREADY  in  1  bus-wide ready; address phase is valid only when HREADY=1
- HWDATA  in  32  unused, ignored
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- IM_enable  out  1  fetch request to IM
- IM_address  out  16  IM word address
- IM_write  out  1  tied 0
- IM_in  out  32  tied 0
- IM_out  in  32  IM read data
- IM_stall  in  1  IM not ready

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, addr_q=0.
  - Outputs: HREADYOUT=1, HRESP=0, HRDATA=0, IM_enable=0, IM_address=0.
- Address capture: when HSEL & HREADY & HTRANS[1]=1, at that clock edge:
  - Legal transfer: addr_q <= HADDR[17:2], state <= FETCH.
  - Illegal transfer: state <= ERR1.
  - Otherwise (no capture): state <= IDLE. IDLE, BUSY and unselected transfers get a zero-wait OKAY.
- Illegal transfer is any of:
  - HWRITE=1
  - HSIZE>2
  - HSIZE=2 with HADDR[1:0]!=0
  - HSIZE=1 with HADDR[0]=1
  - HADDR[31:IM_AW+2]!=0
- Sub-word reads return the full word; the master selects byte lanes.
- FETCH state:
  - IM_enable=1, IM_address=addr_q.
  - HREADYOUT = ~IM_stall, HRESP=0.
  - HRDATA = IM_out when IM_stall=0, else 0.
- HRDATA is 0 in every state other than a completing FETCH cycle.
- ERR1: HREADYOUT=0, HRESP=1. Next state is ERR2 unconditionally; no capture in ERR1.
- ERR2: HREADYOUT=1, HRESP=1. Captures the next transfer as in IDLE.
- Completing FETCH cycle (IM_stall=0): behaves like IDLE for capture.
  - Pipelined next NONSEQ/SEQ → FETCH again with the new addr_q; IM_enable stays 1 and IM restarts.
  - Otherwise → IDLE and IM_enable=0 next cycle.
- Latency with IM's fixed 2-cycle stall:
  - Address phase at cycle T; IM_enable=1 from T+1.
  - HREADYOUT=0 at T+1 and T+2; HREADYOUT=1 with data at T+3.
  - Back-to-back reads complete every 3 cycles.
- Bridge does not count stall cycles; it waits indefinitely on IM_stall.
- Reset asserted mid-FETCH or mid-ERROR: immediately IDLE with reset outputs. No response is owed for the aborted transfer.
- HWDATA is never sampled. IM_write and IM_in are constant 0.

Test Plan:
- Single read: IM word 0x0010 = 0xDEADBEEF; NONSEQ HADDR=0x40, HSIZE=2 at T → HREADYOUT 0 at T+1 and T+2; at T+3 HREADYOUT=1, HRESP=0, HRDATA=0xDEADBEEF; IM_address=0x0010 throughout T+1..T+3; IM_enable=0 at T+4.
- Back-to-back: NONSEQ 0x0, then SEQ 0x4 and 0x8 each presented in the completing cycle → three completions at T+3, T+6, T+9 with words 0, 1, 2; IM_enable stays high T+1..T+9.
- Write: HWRITE=1, HADDR=0x8 → ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); IM_enable stays 0.
- Illegal transfers: HSIZE=2 HADDR=0x2; HSIZE=3; HADDR=0x00040000 → each gets the two-cycle ERROR. HSIZE=1 HADDR=0x6 → OKAY read of word 1.
- Idle/unselected: HTRANS=IDLE or HSEL=0 with HADDR=0x10 → HREADYOUT=1, HRESP=0, IM_enable=0. HREADY=0 during an address phase → no capture.
- Reset abort: rst=0 asynchronously at T+2 of a fetch → same cycle HREADYOUT=1, IM_enable=0, HRDATA=0. After release, a fresh read of 0x40 completes in 3 cycles.

Source files
------------

// File: rtl/ahb_im_bridge.sv
// ahb_im_bridge: AHB-Lite read-only slave that turns bus reads into instruction-memory fetches
module ahb_im_bridge #(
    parameter int IM_AW      = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  IM_enable,
    output logic [IM_AW-1:0]      IM_address,
    output logic                  IM_write,
    output logic [DATA_WIDTH-1:0] IM_in,
    input  logic [DATA_WIDTH-1:0] IM_out,
    input  logic                  IM_stall
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ERR1, S_ERR2} state_t;

    state_t           r_state, w_next;
    logic [IM_AW-1:0] r_addr;
    logic             w_cap, w_bad, w_open, w_unused;

    assign w_cap  = HSEL & HREADY & HTRANS[1];
    assign w_bad  = HWRITE | (HSIZE > 3'd2) | (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) |
                    (HSIZE == 3'd1 && HADDR[0]) | (|HADDR[31:IM_AW+2]);
    // A new address phase is accepted only when this slave is not holding the bus
    assign w_open = (r_state == S_IDLE) | (r_state == S_ERR2) | (r_state == S_FETCH && !IM_stall);

    assign IM_write   = 1'b0;
    assign IM_in      = '0;
    assign IM_address = r_addr;
    assign w_unused   = &{1'b0, HWDATA};

    // State and fetch address registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_open && w_cap && !w_bad) r_addr <= HADDR[IM_AW+1:2];
        end
    end

    // Next-state decode and bus/IM outputs
    always_comb begin
        w_next    = r_state;
        IM_enable = r_state == S_FETCH;
        HREADYOUT = (r_state == S_FETCH) ? !IM_stall : (r_state != S_ERR1);
        HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
        HRDATA    = (r_state == S_FETCH && !IM_stall) ? IM_out : '0;
        if (r_state == S_ERR1) w_next = S_ERR2;
        else if (w_open) w_next = !w_cap ? S_IDLE : w_bad ? S_ERR1 : S_FETCH;
    end
endmodule

// File: tb/tb_ahb_im_bridge.sv
// tb_ahb_im_bridge: directed and randomized checks of the AHB to instruction-memory bridge
module tb_ahb_im_bridge;
    logic        clk = 0;
    logic        rst = 0;
    logic        hsel = 0, hwrite = 0, hr_block = 0;
    logic [31:0] haddr = 0;
    logic [1:0]  htrans = 0;
    logic [2:0]  hsize = 3'd2;
    logic [31:0] HRDATA, IM_in, IM_out;
    logic        HREADYOUT, HRESP, IM_enable, IM_write, IM_stall, HREADY;
    logic [15:0] IM_address;

    logic [31:0] mem [0:65535];
    int          stall_len = 2;
    int          cnt = 0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    // The bridge is the only slave, so the bus HREADY follows its own HREADYOUT
    assign HREADY   = HREADYOUT & ~hr_block;
    assign IM_out   = mem[IM_address];
    assign IM_stall = IM_enable && (cnt < stall_len);

    // IM stub: each fetch stalls for stall_len cycles, then restarts on the next one
    always @(posedge clk or negedge rst)
        if (!rst) cnt <= 0;
        else if (!IM_enable || !IM_stall) cnt <= 0;
        else cnt <= cnt + 1;

    ahb_im_bridge dut (
        .clk(clk), .rst(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HREADY(HREADY), .HWDATA(32'hA5A5_5A5A), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .IM_enable(IM_enable), .IM_address(IM_address),
        .IM_write(IM_write), .IM_in(IM_in), .IM_out(IM_out), .IM_stall(IM_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic go_idle();
        hsel = 0; htrans = 2'd0; hwrite = 0; hsize = 3'd2; haddr = $urandom;
    endtask

    // One transfer with no pipelining; called just after a rising edge with the bridge idle
    task automatic do_xfer(input logic s, input logic [1:0] t, input logic w,
                           input logic [2:0] sz, input logic [31:0] a);
        logic        ill, done;
        int          waits;
        logic [15:0] idx;
        hsel = s; htrans = t; hwrite = w; hsize = sz; haddr = a;
        ill = w || sz > 3'd2 || (a % (32'd1 << sz)) != 0 || a >= 32'h0004_0000;
        idx = 16'(a / 4);
        @(negedge clk);
        chk("idle_rdy", 32'(HREADYOUT), 1);
        chk("idle_resp", 32'(HRESP), 0);
        chk("idle_en", 32'(IM_enable), 0);
        chk("idle_rdata", HRDATA, 0);
        @(posedge clk); #1;
        go_idle();
        if (!(s && t[1])) begin
            @(negedge clk);
            chk("nocap_rdy", 32'(HREADYOUT), 1);
            chk("nocap_resp", 32'(HRESP), 0);
            chk("nocap_en", 32'(IM_enable), 0);
            @(posedge clk); #1;
        end else if (ill) begin
            @(negedge clk);
            chk("err1_rdy", 32'(HREADYOUT), 0);
            chk("err1_resp", 32'(HRESP), 1);
            chk("err1_en", 32'(IM_enable), 0);
            chk("err1_rdata", HRDATA, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("err2_rdy", 32'(HREADYOUT), 1);
            chk("err2_resp", 32'(HRESP), 1);
            chk("err2_en", 32'(IM_enable), 0);
            @(posedge clk); #1;
        end else begin
            done = 0;
            waits = 0;
            for (int c = 0; c < 32 && !done; c++) begin
                @(negedge clk);
                chk("rd_en", 32'(IM_enable), 1);
                chk("rd_addr", 32'(IM_address), 32'(idx));
                chk("rd_resp", 32'(HRESP), 0);
                if (HREADYOUT) begin
                    chk("rd_data", HRDATA, mem[idx]);
                    chk("rd_waits", waits, stall_len);
                    done = 1;
                end else begin
                    chk("rd_stall_data", HRDATA, 0);
                    waits++;
                end
                @(posedge clk); #1;
            end
            chk("rd_timeout", 32'(done), 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[16] = 32'hDEAD_BEEF;
        #12;
        chk("rst_rdy", 32'(HREADYOUT), 1);
        chk("rst_resp", 32'(HRESP), 0);
        chk("rst_rdata", HRDATA, 0);
        chk("rst_en", 32'(IM_enable), 0);
        chk("rst_addr", 32'(IM_address), 0);
        chk("tie_write", 32'(IM_write), 0);
        chk("tie_in", IM_in, 0);
        rst = 1;
        @(posedge clk); #1;

        do_xfer(1, 2'd2, 0, 3'd2, 32'h40);
        do_xfer(1, 2'd2, 1, 3'd2, 32'h8);
        do_xfer(1, 2'd2, 0, 3'd2, 32'h2);
        do_xfer(1, 2'd2, 0, 3'd3, 32'h0);
        do_xfer(1, 2'd2, 0, 3'd2, 32'h0004_0000);
        do_xfer(1, 2'd2, 0, 3'd1, 32'h6);
        do_xfer(1, 2'd0, 0, 3'd2, 32'h10);
        do_xfer(0, 2'd2, 0, 3'd2, 32'h10);
        do_xfer(1, 2'd1, 0, 3'd2, 32'h10);

        hr_block = 1;
        do_xfer(0, 2'd0, 0, 3'd2, 32'h0);
        hsel = 1; htrans = 2'd2; haddr = 32'h10;
        @(posedge clk); #1;
        go_idle();
        hr_block = 0;
        @(negedge clk);
        chk("hready_low_en", 32'(IM_enable), 0);
        chk("hready_low_rdy", 32'(HREADYOUT), 1);
        @(posedge clk); #1;

        stall_len = 2;
        hsel = 1; htrans = 2'd2; hwrite = 0; hsize = 3'd2; haddr = 32'h0;
        for (int k = 0; k < 3; k++)
            for (int c = 1; c <= 3; c++) begin
                @(posedge clk); #1;
                if (c == 3 && k < 2) begin
                    hsel = 1; htrans = 2'd3; haddr = 32'(4 * (k + 1));
                end else go_idle();
                @(negedge clk);
                chk("b2b_en", 32'(IM_enable), 1);
                chk("b2b_rdy", 32'(HREADYOUT), 32'(c == 3));
                chk("b2b_addr", 32'(IM_address), 32'(k));
                chk("b2b_data", HRDATA, (c == 3) ? mem[k] : 32'h0);
            end
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_end_en", 32'(IM_enable), 0);
        @(posedge clk); #1;

        hsel = 1; htrans = 2'd2; hsize = 3'd2; haddr = 32'h40;
        @(posedge clk); #1;
        go_idle();
        @(posedge clk); #3;
        rst = 0;
        #1;
        chk("abort_rdy", 32'(HREADYOUT), 1);
        chk("abort_en", 32'(IM_enable), 0);
        chk("abort_rdata", HRDATA, 0);
        chk("abort_resp", 32'(HRESP), 0);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        do_xfer(1, 2'd2, 0, 3'd2, 32'h40);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            stall_len = $urandom_range(0, 3);
            a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom & 32'h0003_FFFF);
            sz = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            do_xfer($urandom_range(0, 7) != 0, 2'($urandom), $urandom_range(0, 5) == 0, sz, a);
        end
        do_xfer(0, 2'd0, 0, 3'd2, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
